// File: rtl/bram_pkg.sv
// Shared types and limits for the simple-dual-port sample RAM.
// Collision policy selector and clear-engine states live here.
package bram_pkg;

  typedef enum logic {
    WRITE_FIRST,
    READ_FIRST
  } collision_mode_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_e;

  localparam int MAX_RD_PIPE = 2;

endpackage

// File: rtl/bram_sdp_core.sv
// Inferred storage array with one write port and one registered read port.
// Neither the array nor the read register is reset, so this maps onto block RAM.
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read sees the old word on a same-address write, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sdp_param.sv
// Parametrised simple-dual-port RAM wrapper: range checks, collision bypass,
// bulk-clear engine, optional second read stage and read-valid tracking.
module bram_sdp_param
  import bram_pkg::*;
#(
  parameter int              DATA_W    = 9,
  parameter int              DEPTH     = 2048,
  parameter int              ADDR_W    = $clog2(DEPTH),
  parameter int              RD_PIPE   = 1,
  parameter collision_mode_e COLLISION = WRITE_FIRST
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (RD_PIPE < 1 || RD_PIPE > MAX_RD_PIPE || DEPTH < 2) begin : g_bad_params
    $error("bram_sdp_param: RD_PIPE must be 1 or 2 and DEPTH must be at least 2");
  end

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start_i) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic              clearing;
  logic              wrInRange, rdInRange;
  logic              userWe, coreWe, coreRe;
  logic [ADDR_W-1:0] coreWaddr;
  logic [DATA_W-1:0] coreWdata, coreRdata;
  logic              bypass;

  assign clearing   = (state_q == CLR_CLEAR);
  assign clr_busy_o = clearing;
  assign wrInRange  = ({1'b0, wr_addr_i} < DEPTH_L);
  assign rdInRange  = ({1'b0, rd_addr_i} < DEPTH_L);

  // The clearer owns the write port while busy; user writes are dropped then.
  assign userWe    = wr_en_i & ~clearing & wrInRange;
  assign coreWe    = clearing | userWe;
  assign coreWaddr = clearing ? cnt_q : wr_addr_i;
  assign coreWdata = clearing ? '0 : wr_data_i;
  assign coreRe    = rd_en_i & rdInRange;

  assign bypass = (COLLISION == WRITE_FIRST) & rd_en_i & userWe & (wr_addr_i == rd_addr_i);

  bram_sdp_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk_i  (clk_i),
    .we_i   (coreWe),
    .waddr_i(coreWaddr),
    .wdata_i(coreWdata),
    .re_i   (coreRe),
    .raddr_i(rd_addr_i),
    .rdata_o(coreRdata)
  );

  logic              valid1_q, have1_q, zero1_q, byp1_q;
  logic [DATA_W-1:0] bypData1_q;
  logic [DATA_W-1:0] stage1Data;

  // Resettable side-band for stage 1; it masks the unreset core register until a read lands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid1_q   <= 1'b0;
      have1_q    <= 1'b0;
      zero1_q    <= 1'b0;
      byp1_q     <= 1'b0;
      bypData1_q <= '0;
    end else begin
      valid1_q <= rd_en_i;
      if (rd_en_i) begin
        have1_q    <= 1'b1;
        zero1_q    <= ~rdInRange;
        byp1_q     <= bypass;
        bypData1_q <= wr_data_i;
      end
    end
  end

  assign stage1Data = (!have1_q || zero1_q) ? '0 :
                      byp1_q                ? bypData1_q : coreRdata;

  if (RD_PIPE == 2) begin : g_pipe2
    logic [DATA_W-1:0] rdData2_q;
    logic              valid2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rdData2_q <= '0;
        valid2_q  <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) begin
          rdData2_q <= stage1Data;
        end
      end
    end

    assign rd_data_o  = rdData2_q;
    assign rd_valid_o = valid2_q;
  end else begin : g_pipe1
    assign rd_data_o  = stage1Data;
    assign rd_valid_o = valid1_q;
  end

endmodule

// File: tb/tb_bram_sdp_param.sv
// Directed bench for bram_sdp_param: two configurations driven from one sequence,
// read results checked against a per-instance queue of expected words.
module tb_bram_sdp_param;
  import bram_pkg::*;

  typedef struct {
    logic [8:0] data;
    int         due;
    bit         dontCare;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: 2048 deep, 1-cycle read, write-first
  logic        aWrEn, aRdEn, aClrStart, aRdValid, aClrBusy;
  logic [10:0] aWrAddr, aRdAddr;
  logic [8:0]  aWrData, aRdData;

  // Instance B: 1000 deep, 2-cycle read, read-first
  logic        bWrEn, bRdEn, bClrStart, bRdValid, bClrBusy;
  logic [9:0]  bWrAddr, bRdAddr;
  logic [8:0]  bWrData, bRdData;

  exp_t qA[$];
  exp_t qB[$];
  int   cycle = 0;
  int   testsRun = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  bram_sdp_param #(
    .DATA_W(9), .DEPTH(2048), .RD_PIPE(1), .COLLISION(WRITE_FIRST)
  ) dutA (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_en_i(aWrEn), .wr_addr_i(aWrAddr), .wr_data_i(aWrData),
    .rd_en_i(aRdEn), .rd_addr_i(aRdAddr),
    .rd_data_o(aRdData), .rd_valid_o(aRdValid),
    .clr_start_i(aClrStart), .clr_busy_o(aClrBusy)
  );

  bram_sdp_param #(
    .DATA_W(9), .DEPTH(1000), .RD_PIPE(2), .COLLISION(READ_FIRST)
  ) dutB (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_en_i(bWrEn), .wr_addr_i(bWrAddr), .wr_data_i(bWrData),
    .rd_en_i(bRdEn), .rd_addr_i(bRdAddr),
    .rd_data_o(bRdData), .rd_valid_o(bRdValid),
    .clr_start_i(bClrStart), .clr_busy_o(bClrBusy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (aRdValid) begin
      if (qA.size() > 0) e = qA.pop_front();
      else e = exp_t'{data: 9'h0, due: -1, dontCare: 1'b1};
      chk("A valid timing", 32'(cycle), 32'(e.due));
      if (!e.dontCare) chk("A rd_data", 32'(aRdData), 32'(e.data));
    end else if (qA.size() > 0 && qA[0].due <= cycle) begin
      e = qA.pop_front();
      chk("A missing valid", 32'(aRdValid), 32'd1);
    end
    if (bRdValid) begin
      if (qB.size() > 0) e = qB.pop_front();
      else e = exp_t'{data: 9'h0, due: -1, dontCare: 1'b1};
      chk("B valid timing", 32'(cycle), 32'(e.due));
      if (!e.dontCare) chk("B rd_data", 32'(bRdData), 32'(e.data));
    end else if (qB.size() > 0 && qB[0].due <= cycle) begin
      e = qB.pop_front();
      chk("B missing valid", 32'(bRdValid), 32'd1);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic wrA(input logic [10:0] a, input logic [8:0] d);
    aWrEn = 1'b1; aWrAddr = a; aWrData = d;
    applyStimulus();
    aWrEn = 1'b0;
  endtask

  task automatic wrB(input logic [9:0] a, input logic [8:0] d);
    bWrEn = 1'b1; bWrAddr = a; bWrData = d;
    applyStimulus();
    bWrEn = 1'b0;
  endtask

  task automatic readA(input logic [10:0] a, input logic [8:0] e, input bit dc);
    aRdEn = 1'b1; aRdAddr = a;
    qA.push_back(exp_t'{data: e, due: cycle + 1, dontCare: dc});
    applyStimulus();
    aRdEn = 1'b0;
  endtask

  task automatic readB(input logic [9:0] a, input logic [8:0] e);
    bRdEn = 1'b1; bRdAddr = a;
    qB.push_back(exp_t'{data: e, due: cycle + 2, dontCare: 1'b0});
    applyStimulus();
    bRdEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int n;
    int guard;
    rst_n = 1'b0;
    aWrEn = 0; aRdEn = 0; aClrStart = 0; aWrAddr = '0; aRdAddr = '0; aWrData = '0;
    bWrEn = 0; bRdEn = 0; bClrStart = 0; bWrAddr = '0; bRdAddr = '0; bWrData = '0;
    #2;
    chk("A reset rd_data", 32'(aRdData), 32'd0);
    chk("A reset rd_valid", 32'(aRdValid), 32'd0);
    chk("A reset clr_busy", 32'(aClrBusy), 32'd0);
    chk("B reset rd_data", 32'(bRdData), 32'd0);
    chk("B reset rd_valid", 32'(bRdValid), 32'd0);
    chk("B reset clr_busy", 32'(bClrBusy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Basic write then read at the top address
    wrA(11'h7FF, 9'h1A5);
    readA(11'h7FF, 9'h1A5, 1'b0);
    idle(2);

    // Two-stage pipeline with back-to-back reads
    for (int i = 0; i < 4; i++) wrB(10'(i), 9'(16 + i));
    for (int i = 0; i < 4; i++) readB(10'(i), 9'(16 + i));
    idle(3);

    // Same-address collision, write-first
    wrA(11'd5, 9'h0AA);
    aWrEn = 1'b1; aWrAddr = 11'd5; aWrData = 9'h155; aRdEn = 1'b1; aRdAddr = 11'd5;
    qA.push_back(exp_t'{data: 9'h155, due: cycle + 1, dontCare: 1'b0});
    applyStimulus();
    aWrEn = 1'b0; aRdEn = 1'b0;
    readA(11'd5, 9'h155, 1'b0);
    idle(2);

    // Same-address collision, read-first
    wrB(10'd5, 9'h0AA);
    bWrEn = 1'b1; bWrAddr = 10'd5; bWrData = 9'h155; bRdEn = 1'b1; bRdAddr = 10'd5;
    qB.push_back(exp_t'{data: 9'h0AA, due: cycle + 2, dontCare: 1'b0});
    applyStimulus();
    bWrEn = 1'b0; bRdEn = 1'b0;
    readB(10'd5, 9'h155);
    idle(3);

    // Non-power-of-two depth: out-of-range write dropped, read returns 0
    wrB(10'd999, 9'h123);
    wrB(10'd1000, 9'h0FF);
    readB(10'd1000, 9'h000);
    readB(10'd999, 9'h123);
    readB(10'd0, 9'h010);
    readB(10'd1023, 9'h000);
    idle(3);

    // Full clear with a dropped write and an ignored restart
    for (int i = 0; i < 2048; i++) wrA(11'(i), 9'h1FF);
    aClrStart = 1'b1;
    applyStimulus();
    aClrStart = 1'b0;
    chk("A clr_busy rises", 32'(aClrBusy), 32'd1);
    n = 1;
    guard = 0;
    while (aClrBusy && guard < 5000) begin
      if (n == 10) begin aWrEn = 1'b1; aWrAddr = 11'd3; aWrData = 9'h055; end
      if (n == 20) aClrStart = 1'b1;
      applyStimulus();
      aWrEn = 1'b0; aClrStart = 1'b0;
      guard++;
      if (aClrBusy) n++;
    end
    chk("A clr_busy cycles", 32'(n), 32'd2048);
    for (int i = 0; i < 2048; i++) readA(11'(i), 9'h000, 1'b0);
    idle(2);

    // Reset in the middle of a clear
    for (int i = 0; i < 2048; i++) wrA(11'(i), 9'h1FF);
    aClrStart = 1'b1;
    applyStimulus();
    aClrStart = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == 90) begin
        aRdEn = 1'b1; aRdAddr = 11'd2000;
        qA.push_back(exp_t'{data: 9'h1FF, due: cycle + 1, dontCare: 1'b0});
      end
      applyStimulus();
      aRdEn = 1'b0;
    end
    chk("A rd_data before reset", 32'(aRdData), 32'h1FF);
    chk("A busy before reset", 32'(aClrBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("A busy in reset", 32'(aClrBusy), 32'd0);
    chk("A rd_valid in reset", 32'(aRdValid), 32'd0);
    chk("A rd_data in reset", 32'(aRdData), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 2048; i++) begin
      if (i < 100) readA(11'(i), 9'h000, 1'b0);
      else if (i == 100) readA(11'(i), 9'h000, 1'b1);
      else readA(11'(i), 9'h1FF, 1'b0);
    end
    idle(4);

    chk("A scoreboard drained", 32'(qA.size()), 32'd0);
    chk("B scoreboard drained", 32'(qB.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/bram_sdp_param.md
# bram_sdp_param

Parametrised simple-dual-port block RAM that supersedes the fixed 2K×9 single-port sample store. It provides one write port and one read port on a single clock, with configurable width and depth, and a selectable 1- or 2-stage read pipeline with a valid flag. It defines same-address read/write collision behaviour and adds a hardware bulk-clear engine, so the capture path can wipe the buffer between acquisitions without host writes. It sits between the sample capture logic (write side) and the readout/upload logic (read side).

## Interface
- DATA_W, 9, word width in bits
- DEPTH, 2048, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- RD_PIPE, 1, read latency in cycles; legal values 1 or 2
- COLLISION, WRITE_FIRST, same-address same-cycle policy: WRITE_FIRST or READ_FIRST
- CLK  in  1  single clock; all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data; reset 0
- rd_valid  out  1  rd_data carries a new read result this cycle; reset 0
- clr_start  in  1  one-cycle request to zero the whole array
- clr_busy  out  1  clear in progress; reset 0

## Operation
- Write: when wr_en=1, clr_busy=0 and wr_addr<DEPTH, mem[wr_addr]<=wr_data at the posedge. Writes to addresses ≥DEPTH are dropped.
- Read: when rd_en=1, the word at rd_addr enters the read pipe. Reads from addresses ≥DEPTH return 0.
- rd_data holds its last value when no read completes. It is not cleared by a bulk clear.
- Collision (rd_en & wr_en & same address, write accepted):
  - WRITE_FIRST returns wr_data.
  - READ_FIRST returns the prior contents.
  - Collision with a dropped write (clear busy or out of range) always returns the array contents.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_start; the counter loads 0.
  - In CLEAR, each cycle writes 0 to mem[cnt] and increments cnt. After writing DEPTH-1, the FSM returns to IDLE.
  - clr_start during CLEAR is ignored.
  - wr_en during CLEAR is dropped; reads stay serviced and may return partially cleared data.
- Reset: the FSM goes to IDLE, the counter goes to 0, and all pipe registers and outputs go to 0. Array contents are not reset. A reset mid-clear leaves the array partially cleared.

## Timing
- Read latency is RD_PIPE cycles: rd_en sampled at edge N gives rd_data/rd_valid at edge N+RD_PIPE.
- rd_valid is a single-cycle pulse per read. Back-to-back reads give back-to-back valids, at full throughput of one per cycle.
- Write-to-read visibility: a write at edge N is readable by a rd_en sampled at edge N+1. It is visible at edge N itself only under a WRITE_FIRST collision.
- clr_busy rises on the edge that samples clr_start and falls on the edge after the final zero write: high for exactly DEPTH cycles.
- A wr_en in the same cycle as clr_start (FSM in IDLE) is accepted. A wr_en in the following cycle is dropped.

## Structure
- Package bram_pkg holds:
  - typedef enum collision_mode_e {WRITE_FIRST, READ_FIRST};
  - localparam MAX_RD_PIPE=2.
- Sub-module bram_sdp_core holds only the inferred array: write port plus a registered read port, with no reset on the array or its first read register.
- The wrapper bram_sdp_param holds:
  - the clear FSM and counter;
  - the write mux between the user port and the clearer;
  - collision bypass;
  - the optional second pipe stage;
  - valid tracking.
- Elaboration-time assertion: RD_PIPE in {1,2} and DEPTH≥2.

## Test plan
- Basic R/W, DATA_W=9, DEPTH=2048, RD_PIPE=1: write 0x1A5→addr 0x7FF, read 0x7FF → rd_data=0x1A5 with rd_valid one cycle after rd_en.
- Pipeline, RD_PIPE=2: write addrs 0..3 with 0x10..0x13, then read 0..3 on four consecutive cycles → valids on cycles 2..5 with data 0x10..0x13 in order.
- Collision: mem[5]=0x0AA, then same-cycle write 0x155 and read at addr 5 → WRITE_FIRST returns 0x155, READ_FIRST returns 0x0AA. A follow-up read returns 0x155 in both modes.
- Non-power-of-two, DEPTH=1000: write 0x0FF→addr 1000, then read addr 1000 → 0; mem[999] and all other words unchanged.
- Clear: fill all words with 0x1FF, pulse clr_start → clr_busy high exactly DEPTH cycles, and a wr_en of 0x055→addr 3 during the clear is dropped. Afterwards every address reads 0.
- Reset mid-clear: assert RST_N=0 at clear cycle 100 → clr_busy, rd_valid and rd_data go 0 immediately. Addrs 0..99 read 0 and addrs ≥101 keep 0x1FF; addr 100 is either value.
